// File: rtl/array_sp_mask_init_ext.sv
// array_sp_mask_init_ext: parametrised single-port RW SRAM model.
// It provides a per-segment write mask and a pipelined read path of RD_LAT
// cycles with a one-cycle rvalid strobe. Read data is held between reads.
// An optional clear sweep writes INIT_VAL into every word after reset.
module array_sp_mask_init_ext #(
    parameter int               DEPTH         = 8192,
    parameter int               ADDR_W        = 13,
    parameter int               SEG_W         = 5,
    parameter int               SEGS          = 1,
    parameter int               RD_LAT        = 1,
    parameter bit               INIT_ON_RESET = 1'b1,
    parameter logic [SEG_W-1:0] INIT_VAL      = '0
) (
    input  logic                  RW0_clk,
    input  logic                  RW0_rst_n,
    input  logic                  RW0_en,
    input  logic                  RW0_wmode,
    input  logic [ADDR_W-1:0]     RW0_addr,
    input  logic [SEGS-1:0]       RW0_wmask,
    input  logic [SEG_W*SEGS-1:0] RW0_wdata,
    output logic                  RW0_ready,
    output logic                  RW0_rvalid,
    output logic [SEG_W*SEGS-1:0] RW0_rdata
);

    localparam int W = SEG_W * SEGS;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [0:0] ST_RESET = INIT_ON_RESET ? ST_INIT : ST_READY;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [W-1:0]      mem [DEPTH];

    // Read pipeline: stage i holds a read accepted i+1 edges ago
    logic [RD_LAT-1:0] pipe_v;
    logic [W-1:0]      pipe_d [RD_LAT];

    logic accept;
    logic wr_acc;
    logic rd_acc;
    logic init_we;

    assign RW0_ready = (state == ST_READY);
    assign accept    = RW0_en & RW0_ready;
    assign wr_acc    = accept & RW0_wmode;
    assign rd_acc    = accept & ~RW0_wmode;
    // Sweep writes stop while reset is held so word 0 is not rewritten repeatedly
    assign init_we   = (state == ST_INIT) & RW0_rst_n;

    // Sweep controller: step through every word once, then open for requests
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            state <= ST_RESET;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
                state <= ST_READY;
            end
        end
    end

    // Array storage: sweep clear or masked per-segment write; never reset
    always_ff @(posedge RW0_clk) begin
        if (init_we) begin
            mem[cnt] <= {SEGS{INIT_VAL}};
        end else if (wr_acc) begin
            for (int unsigned s = 0; s < SEGS; s++) begin
                if (RW0_wmask[s]) begin
                    mem[RW0_addr][s*SEG_W +: SEG_W] <= RW0_wdata[s*SEG_W +: SEG_W];
                end
            end
        end
    end

    // Read pipeline: array sampled at the accepting edge; data stages load
    // only on a valid entry, so the last stage doubles as the rdata hold register
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            pipe_v <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_acc;
            if (rd_acc) begin
                pipe_d[0] <= mem[RW0_addr];
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
        end
    end

    assign RW0_rvalid = pipe_v[RD_LAT-1];
    assign RW0_rdata  = pipe_d[RD_LAT-1];

endmodule

// File: tb/tb_array_sp_mask_init_ext.sv
// Scoreboard bench for array_sp_mask_init_ext.
// DUT A: DEPTH=16, SEGS=2, RD_LAT=3, sweep enabled, INIT_VAL=5'h1A.
// DUT B: DEPTH=16, SEGS=2, RD_LAT=1, no sweep.
module tb_array_sp_mask_init_ext;

    typedef struct {
        logic [9:0]  d;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    logic       rst_a, en_a, wm_a, rdy_a, rv_a;
    logic [3:0] addr_a;
    logic [1:0] mask_a;
    logic [9:0] wd_a, rd_a;

    logic       rst_b, en_b, wm_b, rdy_b, rv_b;
    logic [3:0] addr_b;
    logic [1:0] mask_b;
    logic [9:0] wd_b, rd_b;

    exp_t       qa[$];
    exp_t       qb[$];
    logic [9:0] hold_a = '0;
    logic [9:0] hold_b = '0;

    array_sp_mask_init_ext #(
        .DEPTH(16), .ADDR_W(4), .SEG_W(5), .SEGS(2), .RD_LAT(3),
        .INIT_ON_RESET(1'b1), .INIT_VAL(5'h1A)
    ) dut_a (
        .RW0_clk(clk), .RW0_rst_n(rst_a), .RW0_en(en_a), .RW0_wmode(wm_a),
        .RW0_addr(addr_a), .RW0_wmask(mask_a), .RW0_wdata(wd_a),
        .RW0_ready(rdy_a), .RW0_rvalid(rv_a), .RW0_rdata(rd_a)
    );

    array_sp_mask_init_ext #(
        .DEPTH(16), .ADDR_W(4), .SEG_W(5), .SEGS(2), .RD_LAT(1),
        .INIT_ON_RESET(1'b0), .INIT_VAL(5'h00)
    ) dut_b (
        .RW0_clk(clk), .RW0_rst_n(rst_b), .RW0_en(en_b), .RW0_wmode(wm_b),
        .RW0_addr(addr_b), .RW0_wmask(mask_b), .RW0_wdata(wd_b),
        .RW0_ready(rdy_b), .RW0_rvalid(rv_b), .RW0_rdata(rd_b)
    );

    always #5 clk = ~clk;

    // Edge counter: value N between posedge N and posedge N+1
    always @(posedge clk) cyc++;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [9:0] d, input logic [1:0] m);
        en_a = 1'b1; wm_a = 1'b1; addr_a = a; wd_a = d; mask_a = m;
        step();
        en_a = 1'b0;
    endtask

    task automatic rd_a_op(input logic [3:0] a, input logic [9:0] exp);
        en_a = 1'b1; wm_a = 1'b0; addr_a = a;
        qa.push_back('{d: exp, due: cyc + 3});
        step();
        en_a = 1'b0;
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [9:0] d, input logic [1:0] m);
        en_b = 1'b1; wm_b = 1'b1; addr_b = a; wd_b = d; mask_b = m;
        step();
        en_b = 1'b0;
    endtask

    task automatic rd_b_op(input logic [3:0] a, input logic [9:0] exp);
        en_b = 1'b1; wm_b = 1'b0; addr_b = a;
        qb.push_back('{d: exp, due: cyc + 1});
        step();
        en_b = 1'b0;
    endtask

    // Monitor A: pops expected reads on rvalid, checks timing, data and hold value
    always @(negedge clk) begin
        if (!rst_a) begin
            qa.delete();
            hold_a = '0;
        end else begin
            if (qa.size() > 0 && qa[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL a_missing_rvalid exp=%h due=%0d cyc=%0d", qa[0].d, qa[0].due, cyc);
                void'(qa.pop_front());
            end
            checks++;
            if (rv_a) begin
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_spurious_rvalid act=%h cyc=%0d", rd_a, cyc);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    if (rd_a !== e.d || cyc != e.due) begin
                        errors++;
                        $display("FAIL a_read act=%h exp=%h cyc=%0d due=%0d", rd_a, e.d, cyc, e.due);
                    end
                    hold_a = e.d;
                end
            end else if (rd_a !== hold_a) begin
                errors++;
                $display("FAIL a_hold act=%h exp=%h cyc=%0d", rd_a, hold_a, cyc);
            end
        end
    end

    // Monitor B: same checks for the RD_LAT=1 instance
    always @(negedge clk) begin
        if (!rst_b) begin
            qb.delete();
            hold_b = '0;
        end else begin
            if (qb.size() > 0 && qb[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL b_missing_rvalid exp=%h due=%0d cyc=%0d", qb[0].d, qb[0].due, cyc);
                void'(qb.pop_front());
            end
            checks++;
            if (rv_b) begin
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_spurious_rvalid act=%h cyc=%0d", rd_b, cyc);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    if (rd_b !== e.d || cyc != e.due) begin
                        errors++;
                        $display("FAIL b_read act=%h exp=%h cyc=%0d due=%0d", rd_b, e.d, cyc, e.due);
                    end
                    hold_b = e.d;
                end
            end else if (rd_b !== hold_b) begin
                errors++;
                $display("FAIL b_hold act=%h exp=%h cyc=%0d", rd_b, hold_b, cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b0; en_a = 1'b0; wm_a = 1'b0; addr_a = '0; mask_a = '0; wd_a = '0;
        rst_b = 1'b0; en_b = 1'b0; wm_b = 1'b0; addr_b = '0; mask_b = '0; wd_b = '0;
        step();
        step();

        // Outputs while in reset
        chk("a_rst_ready",  10'(rdy_a), 10'h0);
        chk("a_rst_rvalid", 10'(rv_a),  10'h0);
        chk("a_rst_rdata",  rd_a,       10'h0);
        chk("b_rst_ready",  10'(rdy_b), 10'h1);
        chk("b_rst_rvalid", 10'(rv_b),  10'h0);
        chk("b_rst_rdata",  rd_b,       10'h0);

        // Sweep with requests presented throughout; all must be ignored
        rst_a = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            en_a = 1'b1; wm_a = i[0]; addr_a = 4'd0; wd_a = 10'h000; mask_a = 2'b11;
            step();
            chk("a_sweep_ready", 10'(rdy_a), (i == 16) ? 10'h1 : 10'h0);
        end
        en_a = 1'b0;

        // Every word cleared to {1A,1A}; back-to-back reads exercise RD_LAT=3 pipelining
        for (int a = 0; a < 16; a++) begin
            rd_a_op(4'(a), 10'h35A);
        end

        // Masked writes and an all-zero-mask no-op
        wr_a(4'd7, 10'h3FF, 2'b11);
        wr_a(4'd7, 10'h000, 2'b01);
        rd_a_op(4'd7, 10'h3E0);
        wr_a(4'd7, 10'h000, 2'b00);
        rd_a_op(4'd7, 10'h3E0);

        // Hold: write lands while the read of the old value is in flight
        wr_a(4'd4, 10'h123, 2'b11);
        rd_a_op(4'd4, 10'h123);
        wr_a(4'd4, 10'h2AB, 2'b11);
        repeat (5) step();
        chk("a_hold_rvalid", 10'(rv_a), 10'h0);
        chk("a_hold_rdata",  rd_a,      10'h123);
        rd_a_op(4'd4, 10'h2AB);
        repeat (4) step();

        // Read in flight when reset hits: it must be dropped
        en_a = 1'b1; wm_a = 1'b0; addr_a = 4'd4;
        step();
        en_a = 1'b0;
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a_rst2_ready",  10'(rdy_a), 10'h0);
            chk("a_rst2_rvalid", 10'(rv_a),  10'h0);
            chk("a_rst2_rdata",  rd_a,       10'h0);
        end

        // Reset after edge 9 of the sweep, then a full restart
        rst_a = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("a_part_sweep_ready", 10'(rdy_a), 10'h0);
        end
        rst_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("a_rst3_ready",  10'(rdy_a), 10'h0);
            chk("a_rst3_rvalid", 10'(rv_a),  10'h0);
            chk("a_rst3_rdata",  rd_a,       10'h0);
        end
        rst_a = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("a_resweep_ready", 10'(rdy_a), (i == 16) ? 10'h1 : 10'h0);
        end
        rd_a_op(4'd0, 10'h35A);
        rd_a_op(4'd4, 10'h35A);
        rd_a_op(4'd7, 10'h35A);
        rd_a_op(4'd15, 10'h35A);
        repeat (4) step();

        // DUT B: no sweep, request at E1 accepted, RD_LAT=1 timing
        rst_b = 1'b1;
        wr_b(4'd3, 10'h155, 2'b11);
        chk("b_ready", 10'(rdy_b), 10'h1);
        rd_b_op(4'd3, 10'h155);
        wr_b(4'd3, 10'h3FF, 2'b10);
        rd_b_op(4'd3, 10'h3F5);
        rd_b_op(4'd3, 10'h3F5);
        wr_b(4'd9, 10'h2C1, 2'b11);
        rd_b_op(4'd9, 10'h2C1);
        rd_b_op(4'd3, 10'h3F5);
        repeat (3) step();
        chk("b_hold_rdata", rd_b, 10'h3F5);

        // Drain, bounded
        for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) begin
            step();
        end
        if (qa.size() > 0 || qb.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain act=%0d exp=0 (outstanding reads)", qa.size() + qb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
